// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-path arbiter slice.
package axi_rd_pkg;

  localparam int ID_M_W = 4;
  localparam int ID_S_W = 8;

  localparam logic [31:0] S0_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] S1_BASE_DEF = 32'h0001_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DERR} state_t;
  typedef enum logic [1:0] {DST_S0, DST_S1, DST_DEF} dest_t;

  // Each slave owns a 64 KiB window, so only the upper half-word decides.
  function automatic dest_t decode_dest(input logic [31:0] addr,
                                        input logic [31:0] s0_base,
                                        input logic [31:0] s1_base);
    if (addr[31:16] == s0_base[31:16]) return DST_S0;
    else if (addr[31:16] == s1_base[31:16]) return DST_S1;
    else return DST_DEF;
  endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-input arbiter: the requester named by i_prio wins a tie.
module axi_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_grant,
  output logic       o_valid
);

  // Preferred requester first, otherwise the other one if it asks.
  always_comb begin
    o_grant = 2'b00;
    if (i_req[i_prio]) o_grant[i_prio] = 1'b1;
    else if (i_req[~i_prio]) o_grant[~i_prio] = 1'b1;
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/axi_read_arbiter.sv
// Read-path crossbar slice: arbitrates two masters onto two SRAM slaves,
// one outstanding read at a time, with an internal DECERR default slave.
//
// state | meaning
// IDLE  | waiting for a master AR; grant and ARREADY are combinational
// ADDR  | registered AR presented to the decoded slave until accepted
// DATA  | R beats passed straight through from slave to granted master
// DERR  | internal default slave returns len+1 DECERR beats
module axi_read_arbiter
  import axi_rd_pkg::*;
#(
  parameter int          NM      = 2,
  parameter int          NS      = 2,
  parameter logic [31:0] S0_BASE = S0_BASE_DEF,
  parameter logic [31:0] S1_BASE = S1_BASE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM*ID_M_W-1:0] ar_id_m,
  input  logic [NM*32-1:0]     ar_addr_m,
  input  logic [NM*4-1:0]      ar_len_m,
  input  logic [NM*3-1:0]      ar_size_m,
  input  logic [NM*2-1:0]      ar_burst_m,
  input  logic [NM-1:0]        ar_valid_m,
  output logic [NM-1:0]        ar_ready_m,
  output logic [NM*ID_M_W-1:0] r_id_m,
  output logic [NM*32-1:0]     r_data_m,
  output logic [NM*2-1:0]      r_resp_m,
  output logic [NM-1:0]        r_last_m,
  output logic [NM-1:0]        r_valid_m,
  input  logic [NM-1:0]        r_ready_m,
  output logic [ID_S_W-1:0]    ar_id_s,
  output logic [31:0]          ar_addr_s,
  output logic [3:0]           ar_len_s,
  output logic [2:0]           ar_size_s,
  output logic [1:0]           ar_burst_s,
  output logic [NS-1:0]        ar_valid_s,
  input  logic [NS-1:0]        ar_ready_s,
  input  logic [NS*ID_S_W-1:0] r_id_s,
  input  logic [NS*32-1:0]     r_data_s,
  input  logic [NS*2-1:0]      r_resp_s,
  input  logic [NS-1:0]        r_last_s,
  input  logic [NS-1:0]        r_valid_s,
  output logic [NS-1:0]        r_ready_s
);

  state_t      r_state, w_state_nxt;
  logic        r_prio, w_prio_nxt;
  logic        r_gnt;
  dest_t       r_dest;
  logic [3:0]  r_ar_id;
  logic [31:0] r_ar_addr;
  logic [3:0]  r_ar_len;
  logic [2:0]  r_ar_size;
  logic [1:0]  r_ar_burst;
  logic [3:0]  r_cnt;

  logic [1:0]  w_grant;
  logic        w_gvalid;
  logic        w_gidx;
  logic        w_take;
  logic [3:0]  w_id_sel;
  logic [31:0] w_addr_sel;
  logic [3:0]  w_len_sel;
  logic [2:0]  w_size_sel;
  logic [1:0]  w_burst_sel;
  dest_t       w_dest_sel;
  logic        w_sidx;
  logic        w_data_done;
  logic        w_derr_done;
  logic        w_unused_rid;

  axi_rr_arb2 u_arb (
    .i_req   (ar_valid_m),
    .i_prio  (r_prio),
    .o_grant (w_grant),
    .o_valid (w_gvalid)
  );

  assign w_gidx = w_grant[1];
  assign w_take = (r_state == IDLE) && w_gvalid && !rst;

  // Select the granted master's AR payload for capture.
  always_comb begin
    w_id_sel    = ar_id_m[ID_M_W*int'(w_gidx) +: ID_M_W];
    w_addr_sel  = ar_addr_m[32*int'(w_gidx) +: 32];
    w_len_sel   = ar_len_m[4*int'(w_gidx) +: 4];
    w_size_sel  = ar_size_m[3*int'(w_gidx) +: 3];
    w_burst_sel = ar_burst_m[2*int'(w_gidx) +: 2];
  end

  assign w_dest_sel = decode_dest(w_addr_sel, S0_BASE, S1_BASE);

  // Slave index is only meaningful in ADDR/DATA, where dest is a real slave.
  assign w_sidx       = (r_dest == DST_S1);
  assign w_data_done  = r_valid_s[w_sidx] & r_ready_m[r_gnt] & r_last_s[w_sidx];
  assign w_derr_done  = r_ready_m[r_gnt] & (r_cnt == 4'd0);
  assign w_unused_rid = ^{r_id_s[15:12], r_id_s[7:4]};

  // State and round-robin priority registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  // Next-state logic; priority flips to the other master after each read.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    case (r_state)
      IDLE: begin
        if (w_gvalid) w_state_nxt = (w_dest_sel == DST_DEF) ? DERR : ADDR;
      end
      ADDR: begin
        if (ar_ready_s[w_sidx]) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_data_done) begin
          w_state_nxt = IDLE;
          w_prio_nxt  = ~r_gnt;
        end
      end
      DERR: begin
        if (w_derr_done) begin
          w_state_nxt = IDLE;
          w_prio_nxt  = ~r_gnt;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture grant, destination and AR payload; count down DECERR beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt      <= 1'b0;
      r_dest     <= DST_S0;
      r_ar_id    <= '0;
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_cnt      <= '0;
    end else if (w_take) begin
      r_gnt      <= w_gidx;
      r_dest     <= w_dest_sel;
      r_ar_id    <= w_id_sel;
      r_ar_addr  <= w_addr_sel;
      r_ar_len   <= w_len_sel;
      r_ar_size  <= w_size_sel;
      r_ar_burst <= w_burst_sel;
      r_cnt      <= w_len_sel;
    end else if ((r_state == DERR) && r_ready_m[r_gnt] && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign ar_ready_m = (r_state == IDLE && !rst) ? w_grant : 2'b00;
  assign ar_id_s    = {3'b000, r_gnt, r_ar_id};
  assign ar_addr_s  = r_ar_addr;
  assign ar_len_s   = r_ar_len;
  assign ar_size_s  = r_ar_size;
  assign ar_burst_s = r_ar_burst;

  // Slave AR valid and R routing; everything not owned by the grant stays 0.
  always_comb begin
    ar_valid_s = '0;
    r_ready_s  = '0;
    r_id_m     = '0;
    r_data_m   = '0;
    r_resp_m   = '0;
    r_last_m   = '0;
    r_valid_m  = '0;
    case (r_state)
      ADDR: ar_valid_s[w_sidx] = 1'b1;
      DATA: begin
        r_valid_m[r_gnt]                        = r_valid_s[w_sidx];
        r_last_m[r_gnt]                         = r_last_s[w_sidx];
        r_resp_m[2*int'(r_gnt) +: 2]            = r_resp_s[2*int'(w_sidx) +: 2];
        r_data_m[32*int'(r_gnt) +: 32]          = r_data_s[32*int'(w_sidx) +: 32];
        r_id_m[ID_M_W*int'(r_gnt) +: ID_M_W]    = r_id_s[ID_S_W*int'(w_sidx) +: ID_M_W];
        r_ready_s[w_sidx]                       = r_ready_m[r_gnt];
      end
      DERR: begin
        r_valid_m[r_gnt]                        = 1'b1;
        r_last_m[r_gnt]                         = (r_cnt == 4'd0);
        r_resp_m[2*int'(r_gnt) +: 2]            = RESP_DECERR;
        r_id_m[ID_M_W*int'(r_gnt) +: ID_M_W]    = r_ar_id;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed vector table,
// hand-written arbitration/backpressure/reset sequences, random traffic.
`timescale 1ns/1ps
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ar_id_m;
  logic [63:0] ar_addr_m;
  logic [7:0]  ar_len_m;
  logic [5:0]  ar_size_m;
  logic [3:0]  ar_burst_m;
  logic [1:0]  ar_valid_m, ar_ready_m;
  logic [7:0]  r_id_m;
  logic [63:0] r_data_m;
  logic [3:0]  r_resp_m;
  logic [1:0]  r_last_m, r_valid_m, r_ready_m;
  logic [7:0]  ar_id_s;
  logic [31:0] ar_addr_s;
  logic [3:0]  ar_len_s;
  logic [2:0]  ar_size_s;
  logic [1:0]  ar_burst_s;
  logic [1:0]  ar_valid_s, ar_ready_s;
  logic [15:0] r_id_s;
  logic [63:0] r_data_s;
  logic [3:0]  r_resp_s;
  logic [1:0]  r_last_s, r_valid_s, r_ready_s;

  always #5 clk = ~clk;

  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .ar_id_m(ar_id_m), .ar_addr_m(ar_addr_m), .ar_len_m(ar_len_m),
    .ar_size_m(ar_size_m), .ar_burst_m(ar_burst_m),
    .ar_valid_m(ar_valid_m), .ar_ready_m(ar_ready_m),
    .r_id_m(r_id_m), .r_data_m(r_data_m), .r_resp_m(r_resp_m),
    .r_last_m(r_last_m), .r_valid_m(r_valid_m), .r_ready_m(r_ready_m),
    .ar_id_s(ar_id_s), .ar_addr_s(ar_addr_s), .ar_len_s(ar_len_s),
    .ar_size_s(ar_size_s), .ar_burst_s(ar_burst_s),
    .ar_valid_s(ar_valid_s), .ar_ready_s(ar_ready_s),
    .r_id_s(r_id_s), .r_data_s(r_data_s), .r_resp_s(r_resp_s),
    .r_last_s(r_last_s), .r_valid_s(r_valid_s), .r_ready_s(r_ready_s)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
    logic [2:0]  size;
    logic [1:0]  burst;
  } req_t;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
    int          exp_dest;
    int          exp_beats;
    logic [1:0]  exp_resp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: phase 0 idle, 1 address to slave, 2 slave data, 3 decode error
  req_t mq[2][$];
  bit   mwait[2];
  int   ph;
  int   g;
  req_t cur;
  int   cdest;
  int   mbeat;
  bit   prio;
  int   grant_log[$];
  int   obs_dest, obs_beats;
  logic [1:0] obs_resp;

  // slave models
  bit          sact[2];
  logic [7:0]  sid[2];
  logic [31:0] saddr[2];
  logic [3:0]  slen[2];
  int          sbeat[2];

  int rmode, smode;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return 0;
    if (a[31:16] == 16'h0001) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] sdata(input int s, input logic [31:0] a, input int beat);
    if (s == 0 && a == 32'h0000_0040 && beat == 0) return 32'hDEAD_BEEF;
    return a ^ {8'(s + 1), 24'h0} ^ (32'(beat) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] pack_log();
    logic [31:0] v = 0;
    foreach (grant_log[i]) v = (v << 4) | 32'(grant_log[i] & 4'hF);
    return v | (32'(grant_log.size()) << 28);
  endfunction

  task automatic model_clear();
    mq[0].delete(); mq[1].delete();
    mwait[0] = 0; mwait[1] = 0;
    sact[0] = 0; sact[1] = 0;
    ph = 0; prio = 0; g = 0; mbeat = 0; cdest = 0;
    grant_log.delete();
  endtask

  task automatic idle_inputs();
    ar_id_m = '0; ar_addr_m = '0; ar_len_m = '0; ar_size_m = '0; ar_burst_m = '0;
    ar_valid_m = '0; r_ready_m = '0; ar_ready_s = '0; r_id_s = '0; r_data_s = '0;
    r_resp_s = '0; r_last_s = '0; r_valid_s = '0;
  endtask

  task automatic push(input int m, input logic [31:0] a, input logic [3:0] len, input logic [3:0] id);
    req_t r;
    r.addr = a; r.len = len; r.id = id; r.size = 3'd2; r.burst = 2'd1;
    mq[m].push_back(r);
  endtask

  task automatic drive();
    for (int m = 0; m < 2; m++) begin
      if (mq[m].size() > 0 && !mwait[m]) begin
        ar_valid_m[m]         = 1'b1;
        ar_id_m[4*m +: 4]     = mq[m][0].id;
        ar_addr_m[32*m +: 32] = mq[m][0].addr;
        ar_len_m[4*m +: 4]    = mq[m][0].len;
        ar_size_m[3*m +: 3]   = mq[m][0].size;
        ar_burst_m[2*m +: 2]  = mq[m][0].burst;
      end else begin
        ar_valid_m[m]         = 1'b0;
        ar_id_m[4*m +: 4]     = 4'($urandom);
        ar_addr_m[32*m +: 32] = $urandom;
        ar_len_m[4*m +: 4]    = 4'($urandom);
        ar_size_m[3*m +: 3]   = 3'($urandom);
        ar_burst_m[2*m +: 2]  = 2'($urandom);
      end
      case (rmode)
        2:       r_ready_m[m] = 1'b1;
        1:       r_ready_m[m] = 1'(cyc % 2);
        default: r_ready_m[m] = ($urandom % 4) != 0;
      endcase
    end
    for (int s = 0; s < 2; s++) begin
      ar_ready_s[s]         = !sact[s] && (smode == 1 || ($urandom % 2) == 0);
      r_valid_s[s]          = sact[s] && (smode == 1 || ($urandom % 3) != 0);
      r_id_s[8*s +: 8]      = sact[s] ? sid[s] : 8'h00;
      r_data_s[32*s +: 32]  = sact[s] ? sdata(s, saddr[s], sbeat[s]) : $urandom;
      r_resp_s[2*s +: 2]    = 2'b00;
      r_last_s[s]           = sact[s] && (sbeat[s] == int'(slen[s]));
    end
  endtask

  task automatic check_update();
    int w;
    int ph_n;
    logic [1:0]  e_arr, e_avs, e_rv, e_rrs;
    logic [38:0] eb;
    w = -1;
    if (ph == 0) begin
      if (ar_valid_m[prio]) w = int'(prio);
      else if (ar_valid_m[!prio]) w = int'(!prio);
    end
    e_arr = (w >= 0) ? 2'(1 << w) : 2'b00;
    chk("ar_ready_m", ar_ready_m, e_arr);
    e_avs = (ph == 1) ? 2'(1 << cdest) : 2'b00;
    chk("ar_valid_s", ar_valid_s, e_avs);
    if (ph == 1)
      chk("ar_payload_s", {ar_id_s, ar_addr_s, ar_len_s, ar_size_s, ar_burst_s},
          {4'(g), cur.id, cur.addr, cur.len, cur.size, cur.burst});
    e_rv = 2'b00; e_rrs = 2'b00;
    if (ph == 2) begin
      e_rv[g]      = r_valid_s[cdest];
      e_rrs[cdest] = r_ready_m[g];
    end
    if (ph == 3) e_rv[g] = 1'b1;
    chk("r_valid_m", r_valid_m, e_rv);
    chk("r_ready_s", r_ready_s, e_rrs);
    for (int m = 0; m < 2; m++)
      if (!(ph >= 2 && m == g))
        chk("r_bus_quiet", {r_id_m[4*m +: 4], r_data_m[32*m +: 32], r_resp_m[2*m +: 2], r_last_m[m]}, 0);

    ph_n = ph;
    if (ph >= 2 && r_valid_m[g] && r_ready_m[g]) begin
      if (ph == 2) eb = {cur.id, sdata(cdest, cur.addr, mbeat), 2'b00, 1'(mbeat == int'(cur.len))};
      else         eb = {cur.id, 32'h0, 2'b11, 1'(mbeat == int'(cur.len))};
      chk("r_beat", {r_id_m[4*g +: 4], r_data_m[32*g +: 32], r_resp_m[2*g +: 2], r_last_m[g]}, eb);
      obs_beats++;
      obs_resp = r_resp_m[2*g +: 2];
      if (r_last_m[g]) begin
        ph_n = 0; prio = !1'(g); mwait[g] = 0;
      end
      mbeat++;
    end
    for (int s = 0; s < 2; s++)
      if (r_valid_s[s] && r_ready_s[s]) begin
        if (r_last_s[s]) sact[s] = 0;
        sbeat[s]++;
      end
    for (int s = 0; s < 2; s++)
      if (ar_valid_s[s] && ar_ready_s[s]) begin
        sact[s] = 1; sid[s] = ar_id_s; saddr[s] = ar_addr_s; slen[s] = ar_len_s; sbeat[s] = 0;
        obs_dest = s;
        if (ph == 1) ph_n = 2;
      end
    for (int m = 0; m < 2; m++)
      if (ar_valid_m[m] && ar_ready_m[m]) begin
        cur = mq[m].pop_front();
        mwait[m] = 1; g = m; grant_log.push_back(m);
        cdest = decode(cur.addr); mbeat = 0;
        obs_dest = 2; obs_beats = 0; obs_resp = 2'bxx;
        ph_n = (cdest == 2) ? 3 : 1;
      end
    ph = ph_n;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    drive();
    #1;
    check_update();
  endtask

  task automatic run_idle(input string name, input int budget);
    int n = 0;
    while (n < budget && !(mq[0].size() == 0 && mq[1].size() == 0 && ph == 0)) begin
      step();
      n++;
    end
    chk({name, "_timeout"}, 1'(n >= budget), 1'b0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {ar_ready_m, ar_valid_s, r_valid_m, r_ready_s}, 0);
  endtask

  vec_t vt[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 32'h0000_0040, 4'd0,  4'h5, 0, 1,  2'b00};
    vt[1] = '{1, 32'h0001_0008, 4'd1,  4'h3, 1, 2,  2'b00};
    vt[2] = '{1, 32'h0002_0000, 4'd2,  4'h9, 2, 3,  2'b11};
    vt[3] = '{0, 32'h0000_FFFC, 4'd15, 4'h1, 0, 16, 2'b00};
    vt[4] = '{1, 32'h0001_FFFF, 4'd0,  4'hE, 1, 1,  2'b00};
    vt[5] = '{0, 32'hFFFF_0000, 4'd0,  4'hF, 2, 1,  2'b11};
    vt[6] = '{0, 32'h8001_0000, 4'd15, 4'h7, 2, 16, 2'b11};
    vt[7] = '{1, 32'h0000_0000, 4'd3,  4'h0, 0, 4,  2'b00};

    rmode = 0; smode = 0;
    idle_inputs();
    model_clear();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk_reset_outputs("reset_outputs");
    chk("reset_payload", {ar_id_s, ar_addr_s, ar_len_s, ar_size_s, ar_burst_s}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // arbitration: simultaneous pairs alternate starting with M0
    push(0, 32'h0000_0040, 4'd0, 4'h2);
    push(1, 32'h0001_0008, 4'd0, 4'h6);
    run_idle("arb_pair1", 200);
    chk("arb_order1", pack_log(), 32'h2000_0001);
    push(0, 32'h0000_0100, 4'd1, 4'h4);
    push(1, 32'h0001_0200, 4'd1, 4'h8);
    run_idle("arb_pair2", 200);
    chk("arb_order2", pack_log(), 32'h4000_0101);

    // directed vector table
    foreach (vt[i]) begin
      push(vt[i].m, vt[i].addr, vt[i].len, vt[i].id);
      run_idle("vec", 400);
      chk("vec_dest", obs_dest, vt[i].exp_dest);
      chk("vec_beats", obs_beats, vt[i].exp_beats);
      chk("vec_resp", obs_resp, vt[i].exp_resp);
    end

    // burst with master backpressure toggling every other cycle
    rmode = 1; smode = 1;
    push(1, 32'h0001_0100, 4'd3, 4'hA);
    run_idle("bp_burst", 100);
    chk("bp_dest", obs_dest, 1);
    chk("bp_beats", obs_beats, 4);

    // random traffic against the model
    rmode = 0; smode = 0;
    for (int k = 0; k < 40; k++) begin
      int sel;
      int both;
      both = ($urandom % 3) == 0 ? 1 : 0;
      for (int m = 0; m < 2; m++) begin
        if (both == 1 || m == int'($urandom % 2)) begin
          req_t r;
          sel = $urandom % 3;
          if (sel == 0)      r.addr = {16'h0000, 16'($urandom)};
          else if (sel == 1) r.addr = {16'h0001, 16'($urandom)};
          else               r.addr = {16'($urandom_range(2, 16'hFFFF)), 16'($urandom)};
          r.len = 4'($urandom); r.id = 4'($urandom);
          r.size = 3'($urandom); r.burst = 2'($urandom);
          mq[m].push_back(r);
        end
      end
      run_idle("rand", 600);
    end

    // reset in the middle of an S0 burst
    rmode = 2; smode = 1;
    push(0, 32'h0000_0040, 4'd0, 4'h1);
    run_idle("pre_rst", 100);
    push(0, 32'h0000_0080, 4'd3, 4'h3);
    begin
      int n = 0;
      while (!(ph == 2 && mbeat == 1) && n < 100) begin
        step();
        n++;
      end
      chk("mid_burst_reach_timeout", 1'(n >= 100), 1'b0);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid_burst");
    idle_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(1, 32'h0001_0010, 4'd1, 4'hC);
    push(0, 32'h0000_0020, 4'd0, 4'hD);
    run_idle("post_rst", 200);
    chk("post_rst_order", pack_log(), 32'h2000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Read-path crossbar slice inside the AXI interconnect, between CPU_wrapper (masters M0 = instruction fetch, M1 = data load) and the SRAM slaves (S0 = IM, S1 = DM).
- Arbitrates AR requests from two masters and decodes the address to one slave.
- Routes the R burst back to the granted master.
- Serves unmapped addresses from an internal default slave that returns DECERR.

Parameters:
- NM, 2, number of masters.
- NS, 2, number of real slaves.
- S0_BASE, 32'h0000_0000, IM base; window 64 KiB.
- S1_BASE, 32'h0001_0000, DM base; window 64 KiB.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- ar_id_m  input  NM*4  ARID per master; master m occupies bits [4m+3:4m]
- ar_addr_m  input  NM*32  ARADDR per master
- ar_len_m  input  NM*4  ARLEN per master
- ar_size_m  input  NM*3  ARSIZE per master
- ar_burst_m  input  NM*2  ARBURST per master
- ar_valid_m  input  NM  ARVALID per master
- ar_ready_m  output  NM  ARREADY per master
- r_id_m  output  NM*4  RID per master
- r_data_m  output  NM*32  RDATA per master
- r_resp_m  output  NM*2  RRESP per master
- r_last_m  output  NM  RLAST per master
- r_valid_m  output  NM  RVALID per master
- r_ready_m  input  NM  RREADY per master
- ar_id_s  output  8  ARID to slaves, {4'(grant), master ARID}; shared bus
- ar_addr_s / ar_len_s / ar_size_s / ar_burst_s  output  32/4/3/2  shared AR payload to slaves
- ar_valid_s  output  NS  ARVALID per slave
- ar_ready_s  input  NS  ARREADY per slave
- r_id_s  input  NS*8  RID per slave
- r_data_s  input  NS*32  RDATA per slave
- r_resp_s  input  NS*2  RRESP per slave
- r_last_s  input  NS  RLAST per slave
- r_valid_s  input  NS  RVALID per slave
- r_ready_s  output  NS  RREADY per slave

Behaviour:
- Reset: asynchronous, active-high, on rst; clock clk. Reset takes effect immediately, including mid-burst.
  - FSM goes to IDLE; prio=0 (M0 preferred); all valid/ready outputs 0; payload registers 0.
  - No burst resumes after reset.
- States: IDLE, ADDR, DATA, DERR.
- IDLE:
  - Grant g = prio master if its ar_valid_m is set, else the other master if set.
  - ar_ready_m[g]=1 combinationally in the same cycle; the loser sees 0.
  - On grant, register payload, g, and dest:
    - dest = S0 if addr[31:16]==S0_BASE[31:16];
    - dest = S1 if addr[31:16]==S1_BASE[31:16];
    - else dest = DEFAULT.
  - Next state: ADDR for a real slave, DERR for DEFAULT.
  - No request: stay in IDLE.
- ADDR:
  - ar_valid_s[dest]=1, payload stable from registers; the other slave sees 0.
  - ar_valid_s stays high until ar_ready_s[dest]; then → DATA.
  - AR latency: master handshake to slave ARVALID = 1 cycle.
- DATA:
  - Combinational pass-through: r_*_s[dest] → r_*_m[g], with r_id_m[g] = r_id_s[dest][3:0].
  - r_ready_s[dest] = r_ready_m[g]. The non-granted master sees r_valid=0.
  - On r_valid & r_ready & r_last → IDLE, with prio = ~g (round-robin).
  - Slave beats are never dropped or duplicated; backpressure propagates in 0 cycles.
- DERR (default slave):
  - Beat counter loaded with the registered len.
  - Drives r_valid_m[g]=1, r_data=0, r_resp=2'b11 (DECERR), r_id = registered ID.
  - r_last=1 when counter==0. Each handshake decrements the counter.
  - Last handshake → IDLE, with prio = ~g.
  - len=0 gives exactly 1 beat; len=15 gives 16 beats.
- Simultaneous ar_valid from both masters in IDLE: only the prio master is granted. The other holds its request; it is granted in the next IDLE because prio flips.
- Only one outstanding read at a time. ar_ready_m=0 for all masters outside IDLE.
- Unused bits: r_* outputs for a non-granted master are driven 0.

Decomposition:
- Shared package axi_rd_pkg holds:
  - state enum {IDLE, ADDR, DATA, DERR};
  - dest enum {DST_S0, DST_S1, DST_DEF};
  - RESP_OKAY=2'b00, RESP_DECERR=2'b11;
  - slave base constants;
  - ID widths 4/8.
- One sub-module is natural: axi_rr_arb2, a 2-input round-robin arbiter (req[1:0], prio in → grant one-hot, valid). The FSM owns and updates the prio register.

Test Plan:
- Single read: M0 reads addr 0x0000_0040, len=0. Required response:
  - ar_valid_s[0] rises 1 cycle after the M0 handshake, with ar_id_s=8'h0?;
  - slave returns 32'hDEAD_BEEF, RLAST;
  - M0 receives the same data, RRESP=00, RID = original ID;
  - FSM back in IDLE.
- Arbitration: M0 and M1 both assert AR in the same cycle after reset. Required response:
  - M0 is granted first;
  - M1 is granted next, ar_id_s[7:4]=1, routed to S1 for addr 0x0001_0008;
  - third concurrent request pair grants M0 again (alternation).
- Burst with backpressure: M1 reads len=3 from S1 and toggles r_ready_m every other cycle. Required response:
  - exactly 4 beats in order;
  - r_ready_s mirrors r_ready_m;
  - RLAST only on beat 4.
- Decode error: M1 reads 0x0002_0000, len=2. Required response:
  - no slave sees ar_valid;
  - 3 beats with RRESP=11, RDATA=0, RLAST on beat 3.
- Reset mid-burst: assert rst during beat 2 of a len=3 S0 burst. Required response:
  - all valid/ready outputs drop to 0 asynchronously;
  - after release, a new M1 request is served normally, with prio=M0 preference restored.
